multicycle_ctrl: RTL and testbench

- Second-generation CR16-style multicycle controller/decoder.
- Sequences fetch, decode, execute, memory and writeback for the datapath (PC, IR, regfile, ALU, single-port memory).
- Parametrised in data width and register count.
- Adds loads/stores with a memory-ready handshake, Bcond/Jcond/JAL control flow, condition evaluation on Z/L/N/C/F, immediate extension and flag write control.

---
 rtl/cr16_pkg.sv | 71 +++++++
 rtl/cond_eval.sv | 37 +++
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16-style multicycle controller.
package cr16_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_LD_ADDR = 3'd3,
    S_LD_WB   = 3'd4,
    S_ST      = 3'd5,
    S_BR      = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LOAD, K_STOR, K_BCOND, K_JCOND, K_JAL, K_NOP
  } kind_t;

  localparam logic [3:0] OPC_RTYPE   = 4'b0000;
  localparam logic [3:0] OPC_SPECIAL = 4'b0100;
  localparam logic [3:0] OPC_BCOND   = 4'b1100;
  localparam logic [3:0] OPC_LUI     = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;

  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_ADDC = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SUBC = 4'b1010;
  localparam logic [3:0] OP_CMP  = 4'b1011;

  localparam logic [3:0] CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4,  CC_LS = 4'd5,  CC_GT = 4'd6,  CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8,  CC_FC = 4'd9,  CC_LO = 4'd10, CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12, CC_GE = 4'd13, CC_UC = 4'd14, CC_NV = 4'd15;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC1 = 2'd2;

  // Instruction class from opcode and extension fields
  function automatic kind_t classify(input logic [15:0] ins);
    kind_t k;
    k = K_ALU;
    case (ins[15:12])
      OPC_SPECIAL: begin
        case (ins[7:4])
          EXT_LOAD:  k = K_LOAD;
          EXT_STOR:  k = K_STOR;
          EXT_JCOND: k = K_JCOND;
          EXT_JAL:   k = K_JAL;
          default:   k = K_NOP;
        endcase
      end
      OPC_BCOND: k = K_BCOND;
      default:   k = K_ALU;
    endcase
    return k;
  endfunction

  // ALU operations that update the PSR
  function automatic logic is_flag_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluation against PSR flags.
module cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       z,
  input  logic       l,
  input  logic       n,
  input  logic       c,
  input  logic       f,
  output logic       taken
);

  // Condition table lookup
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_HI:   taken = l;
      CC_LS:   taken = !l;
      CC_GT:   taken = n;
      CC_LE:   taken = !n;
      CC_FS:   taken = f;
      CC_FC:   taken = !f;
      CC_LO:   taken = !l && !z;
      CC_HS:   taken = l || z;
      CC_LT:   taken = !n && !z;
      CC_GE:   taken = n || z;
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer and decoder.
module multicycle_ctrl
  import cr16_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NREG       = 16,
  parameter bit          ZEXT_LOGIC = 1'b1,
  localparam int unsigned RW        = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              Z,
  input  logic              L,
  input  logic              N,
  input  logic              C,
  input  logic              F,
  input  logic              mem_rdy,
  output logic              pc_en,
  output logic              pc_ld,
  output logic              ir_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic              addr_sel,
  output logic              reg_we,
  output logic [NREG-1:0]   reg_en,
  output logic [1:0]        wb_sel,
  output logic              imm_en,
  output logic              flag_we,
  output logic [3:0]        op,
  output logic [RW-1:0]     rsrc,
  output logic [RW-1:0]     rdest,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        state_dbg
);

  state_t            state, state_nxt;
  kind_t             kind;
  logic [3:0]        opc, ext;
  logic [3:0]        dec_op;
  logic              dec_imm_en;
  logic [DATA_W-1:0] dec_imm;
  logic [RW-1:0]     dec_rsrc, dec_rdest;
  logic [NREG-1:0]   dec_reg_en;
  logic              taken;

  assign opc        = instr[15:12];
  assign ext        = instr[7:4];
  assign kind       = classify(instr);
  assign dec_rdest  = instr[8 +: RW];
  assign dec_rsrc   = instr[0 +: RW];
  assign dec_reg_en = {{(NREG-1){1'b0}}, 1'b1} << dec_rdest;
  assign state_dbg  = state;

  cond_eval u_cond_eval (
    .cond  (instr[11:8]),
    .z     (Z),
    .l     (L),
    .n     (N),
    .c     (C),
    .f     (F),
    .taken (taken)
  );

  // ALU opcode and immediate extraction
  always_comb begin
    dec_op     = 4'd0;
    dec_imm_en = 1'b0;
    dec_imm    = '0;
    case (opc)
      OPC_RTYPE:   dec_op = ext;
      OPC_SPECIAL: dec_op = 4'd0;
      OPC_BCOND:   dec_imm = DATA_W'($signed(instr[7:0]));
      OPC_LUI: begin
        dec_op     = opc;
        dec_imm_en = 1'b1;
        dec_imm    = DATA_W'({instr[7:0], 8'h00});
      end
      default: begin
        dec_op     = opc;
        dec_imm_en = 1'b1;
        if (ZEXT_LOGIC && (opc inside {OP_AND, OP_OR, OP_XOR}))
          dec_imm = DATA_W'(instr[7:0]);
        else
          dec_imm = DATA_W'($signed(instr[7:0]));
      end
    endcase
  end

  // State register; reset parks the sequencer in FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next state and decoded outputs; everything forced low while in reset
  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    pc_ld     = 1'b0;
    ir_en     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    reg_we    = 1'b0;
    flag_we   = 1'b0;
    imm_en    = 1'b0;
    wb_sel    = WB_ALU;
    op        = 4'd0;
    rsrc      = '0;
    rdest     = '0;
    imm       = '0;
    reg_en    = '0;
    if (reset) begin
      if (state != S_FETCH) begin
        op     = dec_op;
        imm_en = dec_imm_en;
        imm    = dec_imm;
        rsrc   = dec_rsrc;
        rdest  = dec_rdest;
        reg_en = dec_reg_en;
      end
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            ir_en     = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          case (kind)
            K_ALU:                    state_nxt = S_EXEC;
            K_LOAD:                   state_nxt = S_LD_ADDR;
            K_STOR:                   state_nxt = S_ST;
            K_BCOND, K_JCOND, K_JAL:  state_nxt = S_BR;
            default: begin
              pc_en     = 1'b1;
              state_nxt = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          reg_we    = (dec_op != OP_CMP);
          flag_we   = is_flag_op(dec_op);
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
        S_ST: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_rdy) begin
            pc_en     = 1'b1;
            state_nxt = S_FETCH;
          end
        end
        S_LD_ADDR: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_rdy) state_nxt = S_LD_WB;
        end
        S_LD_WB: begin
          reg_we    = 1'b1;
          wb_sel    = WB_MEM;
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
        S_BR: begin
          if (kind == K_JAL) begin
            reg_we = 1'b1;
            wb_sel = WB_PC1;
          end
          if ((kind == K_JAL) || taken) pc_ld = 1'b1;
          else                          pc_en = 1'b1;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl (NREG=16 zext and NREG=8 sext builds).
module tb_multicycle_ctrl;

  localparam logic [8:0] S_PCEN = 9'h100, S_PCLD = 9'h080, S_IREN = 9'h040;
  localparam logic [8:0] S_MREQ = 9'h020, S_MWE  = 9'h010, S_ASEL = 9'h008;
  localparam logic [8:0] S_RWE  = 9'h004, S_FWE  = 9'h002, S_IMM  = 9'h001;

  logic        clk, reset, Z, L, N, C, F, mem_rdy;
  logic [15:0] instr;

  logic        pc_en, pc_ld, ir_en, mem_req, mem_we, addr_sel, reg_we, imm_en, flag_we;
  logic [15:0] reg_en, imm;
  logic [1:0]  wb_sel;
  logic [3:0]  op, rsrc, rdest;
  logic [2:0]  state_dbg;

  logic        pc_en8, pc_ld8, ir_en8, mem_req8, mem_we8, addr_sel8, reg_we8, imm_en8, flag_we8;
  logic [7:0]  reg_en8;
  logic [15:0] imm8;
  logic [1:0]  wb_sel8;
  logic [3:0]  op8;
  logic [2:0]  rsrc8, rdest8, state8;

  logic [8:0]  strb, strb8;
  int          n_vec = 0;
  int          n_err = 0;

  assign strb  = {pc_en, pc_ld, ir_en, mem_req, mem_we, addr_sel, reg_we, flag_we, imm_en};
  assign strb8 = {pc_en8, pc_ld8, ir_en8, mem_req8, mem_we8, addr_sel8, reg_we8, flag_we8, imm_en8};

  multicycle_ctrl #(.DATA_W(16), .NREG(16), .ZEXT_LOGIC(1'b1)) u_dut (
    .clk(clk), .reset(reset), .instr(instr), .Z(Z), .L(L), .N(N), .C(C), .F(F),
    .mem_rdy(mem_rdy), .pc_en(pc_en), .pc_ld(pc_ld), .ir_en(ir_en), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .reg_we(reg_we), .reg_en(reg_en),
    .wb_sel(wb_sel), .imm_en(imm_en), .flag_we(flag_we), .op(op), .rsrc(rsrc),
    .rdest(rdest), .imm(imm), .state_dbg(state_dbg)
  );

  multicycle_ctrl #(.DATA_W(16), .NREG(8), .ZEXT_LOGIC(1'b0)) u_dut8 (
    .clk(clk), .reset(reset), .instr(instr), .Z(Z), .L(L), .N(N), .C(C), .F(F),
    .mem_rdy(mem_rdy), .pc_en(pc_en8), .pc_ld(pc_ld8), .ir_en(ir_en8), .mem_req(mem_req8),
    .mem_we(mem_we8), .addr_sel(addr_sel8), .reg_we(reg_we8), .reg_en(reg_en8),
    .wb_sel(wb_sel8), .imm_en(imm_en8), .flag_we(flag_we8), .op(op8), .rsrc(rsrc8),
    .rdest(rdest8), .imm(imm8), .state_dbg(state8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch with immediate mem_rdy and land in DECODE
  task automatic fetch_decode(input logic [15:0] ins);
    instr   = ins;
    mem_rdy = 1'b1;
    tick();
  endtask

  function automatic logic exp_taken(input logic [3:0] cc, input logic [4:0] fl);
    logic z, l, n, c, f;
    {z, l, n, c, f} = fl;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; reset = 1'b0; instr = 16'h0000; {Z, L, N, C, F} = 5'b0; mem_rdy = 1'b0;
    #2;
    check("rst_strb", 32'(strb), 32'h0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_fields", {op, rsrc, rdest, wb_sel}, 32'h0);
    check("rst_imm", 32'(imm), 32'h0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("fetch_strb", 32'(strb), 32'(S_MREQ));

    // ADDI r1 += 3
    instr = 16'h5103; mem_rdy = 1'b1;
    #1;
    check("addi_fetch_strb", 32'(strb), 32'(S_MREQ | S_IREN));
    tick();
    check("addi_dec_state", 32'(state_dbg), 32'd1);
    check("addi_dec_strb", 32'(strb), 32'(S_IMM));
    tick();
    check("addi_ex_state", 32'(state_dbg), 32'd2);
    check("addi_ex_strb", 32'(strb), 32'(S_PCEN | S_RWE | S_FWE | S_IMM));
    check("addi_ex_imm", 32'(imm), 32'h0003);
    check("addi_ex_regen", 32'(reg_en), 32'h0002);
    check("addi_ex_op", 32'(op), 32'h5);
    check("addi_ex_wbsel", 32'(wb_sel), 32'd0);
    tick();
    check("addi_back_fetch", 32'(state_dbg), 32'd0);

    // ANDI: zero-extended on the zext build, sign-extended on the sext build
    fetch_decode(16'h1280);
    check("andi_imm", 32'(imm), 32'h0080);
    check("andi_imm_sext", 32'(imm8), 32'hFF80);
    check("andi_op", 32'(op8), 32'h1);
    tick();
    check("andi_ex_strb", 32'(strb), 32'(S_PCEN | S_RWE | S_IMM));
    tick();

    fetch_decode(16'h5280);
    check("addi_neg_imm", 32'(imm), 32'hFF80);
    tick(); tick();

    fetch_decode(16'hF312);
    check("lui_imm", 32'(imm), 32'h1200);
    check("lui_op", 32'(op), 32'hF);
    tick();
    check("lui_ex_strb", 32'(strb), 32'(S_PCEN | S_RWE | S_IMM));
    check("lui_rdest", 32'(rdest), 32'd3);
    tick();

    // CMP r1,r2: flags only, no register write
    fetch_decode(16'h01B2);
    check("cmp_dec_strb", 32'(strb), 32'h0);
    tick();
    check("cmp_ex_strb", 32'(strb), 32'(S_PCEN | S_FWE));
    check("cmp_ex_op", 32'(op), 32'hB);
    tick();

    // LOAD r2 <- [r3] with two wait cycles
    fetch_decode(16'h4203);
    mem_rdy = 1'b0;
    tick();
    check("ld_addr_state", 32'(state_dbg), 32'd3);
    check("ld_addr_strb", 32'(strb), 32'(S_MREQ | S_ASEL));
    tick();
    check("ld_wait1", 32'(state_dbg), 32'd3);
    tick();
    check("ld_wait2", 32'(state_dbg), 32'd3);
    mem_rdy = 1'b1;
    #1;
    check("ld_rdy_strb", 32'(strb), 32'(S_MREQ | S_ASEL));
    tick();
    check("ld_wb_state", 32'(state_dbg), 32'd4);
    check("ld_wb_strb", 32'(strb), 32'(S_PCEN | S_RWE));
    check("ld_wb_sel", 32'(wb_sel), 32'd1);
    check("ld_wb_regen", 32'(reg_en), 32'h0004);
    tick();
    check("ld_back_fetch", 32'(state_dbg), 32'd0);

    // STOR with one wait cycle
    fetch_decode(16'h4143);
    mem_rdy = 1'b0;
    tick();
    check("st_state", 32'(state_dbg), 32'd5);
    check("st_strb", 32'(strb), 32'(S_MREQ | S_MWE | S_ASEL));
    tick();
    check("st_wait", 32'(state_dbg), 32'd5);
    mem_rdy = 1'b1;
    #1;
    check("st_rdy_strb", 32'(strb), 32'(S_PCEN | S_MREQ | S_MWE | S_ASEL));
    tick();
    check("st_back_fetch", 32'(state_dbg), 32'd0);

    // Unknown 0100 extension behaves as NOP
    fetch_decode(16'h4020);
    check("nop_dec_strb", 32'(strb), 32'(S_PCEN));
    tick();
    check("nop_back_fetch", 32'(state_dbg), 32'd0);

    // Bcond EQ taken / not taken, cond 1111 never
    {Z, L, N, C, F} = 5'b10000;
    fetch_decode(16'hC0FE);
    tick();
    check("beq_state", 32'(state_dbg), 32'd6);
    check("beq_taken_strb", 32'(strb), 32'(S_PCLD));
    check("beq_disp", 32'(imm), 32'hFFFE);
    tick();
    {Z, L, N, C, F} = 5'b00000;
    fetch_decode(16'hC0FE);
    tick();
    check("beq_not_taken_strb", 32'(strb), 32'(S_PCEN));
    tick();
    {Z, L, N, C, F} = 5'b11111;
    fetch_decode(16'hCFFE);
    tick();
    check("bnever_strb", 32'(strb), 32'(S_PCEN));
    tick();

    // JAL r14, r5
    {Z, L, N, C, F} = 5'b00000;
    fetch_decode(16'h4E85);
    tick();
    check("jal_strb", 32'(strb), 32'(S_PCLD | S_RWE));
    check("jal_wbsel", 32'(wb_sel), 32'd2);
    check("jal_regen", 32'(reg_en), 32'h4000);
    check("jal_rdest", 32'(rdest), 32'hE);
    check("jal_rsrc", 32'(rsrc), 32'h5);
    check("jal8_state", 32'(state8), 32'd6);
    check("jal8_strb", 32'(strb8), 32'(S_PCLD | S_RWE));
    check("jal8_wbsel", 32'(wb_sel8), 32'd2);
    check("jal8_rdest", 32'(rdest8), 32'h6);
    check("jal8_rsrc", 32'(rsrc8), 32'h5);
    check("jal8_regen", 32'(reg_en8), 32'h40);
    tick();

    // Async reset while stalled in LD_ADDR
    fetch_decode(16'h4203);
    mem_rdy = 1'b0;
    tick();
    check("mid_ld_strb", 32'(strb), 32'(S_MREQ | S_ASEL));
    reset = 1'b0;
    #1;
    check("mid_rst_strb", 32'(strb), 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_fields", {reg_en, rdest, rsrc}, 32'h0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rel_state", 32'(state_dbg), 32'd0);
    check("rel_strb", 32'(strb), 32'(S_MREQ));

    // Full condition table sweep through Bcond
    for (int cc = 0; cc < 16; cc++) begin
      for (int fl = 0; fl < 32; fl++) begin
        {Z, L, N, C, F} = 5'(fl);
        fetch_decode({4'hC, 4'(cc), 8'h02});
        tick();
        check($sformatf("cond%0d_flags%0d", cc, fl), 32'({pc_ld, pc_en}),
              exp_taken(4'(cc), 5'(fl)) ? 32'h2 : 32'h1);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
